// File: rtl/display_scheduler.sv
// display_scheduler: scans six BCD digits into the output shift
// register, latches each frame, and makes the seconds count tick.
//
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_srrdy         shift register idle, may accept a load
//   i_htens_zero    hours-tens digit is zero
//   o_srload        1-cycle load strobe to the shift register
//   o_muxsel[2:0]   digit select, NUM_DIGITS-1 down to 0
//   o_latch         1-cycle frame latch strobe
//   o_cnt_en        1-cycle tick every TICK_DIV cycles
//   o_blank         current digit blanked
//   o_busy          frame transfer in progress
// Build option: LEADING_ZERO_BLANK_EN blanks a leading hours zero.
module display_scheduler #(
  parameter int TICK_DIV    = 1000,
  parameter int REFRESH_DIV = 64,
  parameter int NUM_DIGITS  = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_srrdy,
  input  logic       i_htens_zero,
  output logic       o_srload,
  output logic [2:0] o_muxsel,
  output logic       o_latch,
  output logic       o_cnt_en,
  output logic       o_blank,
  output logic       o_busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_LO,
    WAIT_HI,
    LATCH
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [2:0]    mux_d;
  logic          pend_q;
  logic          pend_d;
  logic [TW-1:0] tick_q;
  logic [RW-1:0] ref_q;
  logic          tick_wrap;
  logic          ref_wrap;
  logic          srload_d;
  logic          latch_d;
  logic          busy_d;
  logic          blank_d;

  assign tick_wrap = (tick_q == TW'(TICK_DIV - 1));
  assign ref_wrap  = (ref_q == RW'(REFRESH_DIV - 1));

  // Free-running prescalers; independent of the FSM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_q   <= '0;
      ref_q    <= '0;
      o_cnt_en <= 1'b0;
    end else begin
      tick_q   <= tick_wrap ? '0 : tick_q + 1'b1;
      ref_q    <= ref_wrap ? '0 : ref_q + 1'b1;
      // Registered: high while tick_q sits at TICK_DIV-1.
      o_cnt_en <= (tick_q == TW'(TICK_DIV - 2));
    end
  end

  always_comb begin
    state_d = state_q;
    mux_d   = o_muxsel;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q && i_srrdy) begin
          pend_d  = 1'b0;
          mux_d   = 3'(NUM_DIGITS - 1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!i_srrdy) begin
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (i_srrdy) begin
          if (o_muxsel == 3'd0) begin
            state_d = LATCH;
          end else begin
            mux_d   = o_muxsel - 3'd1;
            state_d = LOAD;
          end
        end
      end
      LATCH: begin
        mux_d   = 3'd0;
        state_d = IDLE;
      end
      default: begin
        mux_d   = 3'd0;
        state_d = IDLE;
      end
    endcase
    // A wrap coinciding with the accept re-arms pending.
    if (ref_wrap) begin
      pend_d = 1'b1;
    end
  end

  assign srload_d = (state_d == LOAD);
  assign latch_d  = (state_d == LATCH);
  assign busy_d   = (state_d != IDLE);

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_d = i_htens_zero &&
                   (mux_d == 3'd5) &&
                   ((state_d == LOAD) ||
                    (state_d == WAIT_LO) ||
                    (state_d == WAIT_HI));
`else
  logic unused_htens;
  assign unused_htens = i_htens_zero;
  assign blank_d      = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      o_muxsel <= 3'd0;
      o_srload <= 1'b0;
      o_latch  <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      o_muxsel <= mux_d;
      o_srload <= srload_d;
      o_latch  <= latch_d;
      o_busy   <= busy_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_blank <= 1'b0;
    end else begin
      o_blank <= blank_d;
    end
  end
`else
  assign o_blank = blank_d;
`endif

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: scoreboard bench for display_scheduler
// with a shift-register model driving i_srrdy.
module tb_display_scheduler;

  localparam int T = 10;
  localparam int R = 4;
  localparam int N = 6;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_srrdy;
  logic       i_htens_zero;
  logic       o_srload;
  logic [2:0] o_muxsel;
  logic       o_latch;
  logic       o_cnt_en;
  logic       o_blank;
  logic       o_busy;

  display_scheduler #(
    .TICK_DIV(T),
    .REFRESH_DIV(R),
    .NUM_DIGITS(N)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_srrdy(i_srrdy),
    .i_htens_zero(i_htens_zero),
    .o_srload(o_srload),
    .o_muxsel(o_muxsel),
    .o_latch(o_latch),
    .o_cnt_en(o_cnt_en),
    .o_blank(o_blank),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit is_latch;
    int mux;
    int ed;
  } ev_t;

  ev_t q[$];
  ev_t cur;

  int errors = 0;
  int checks = 0;

  // Model state: edges since reset release.
  int ed = 0;
  bit pend = 0;
  int fs = 1;
  int lat = 0;
  int fh = 0;
  int idle_from = 0;
  bit m_rdy, m_hz, m_acc;
  bit exp_cnt_en = 0;
  bit exp_busy = 0;
  bit exp_blank = 0;

  // Shift-register model state.
  int hold_len = 8;
  int sr_cnt = 0;
  int ext_cnt = 0;
  bit ld, sr_busy;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               name, act, exp, ed);
    end
  endtask

  // Reference model. A frame accepted at edge e loads digit
  // k after edge e+k*(H+2): the SR drops rdy the cycle after
  // a load, holds it low H cycles, and the rise is seen one
  // edge later. The latch follows N*(H+2) edges after e.
  initial forever begin
    @(posedge i_clk);
    if (i_rst_n) begin
      m_rdy = i_srrdy;
      m_hz  = i_htens_zero;
      ed++;
      m_acc = (ed > idle_from) && pend && m_rdy;
      if (m_acc) begin
        pend = 0;
        fs = ed;
        fh = hold_len;
        lat = ed + N * (fh + 2);
        idle_from = lat + 1;
        for (int k = 0; k < N; k++)
          q.push_back('{1'b0, N - 1 - k, ed + k * (fh + 2)});
        q.push_back('{1'b1, 0, lat});
      end
      if (ed % R == 0) pend = 1;
      exp_cnt_en = (ed % T == T - 1);
      exp_busy = (ed >= fs) && (ed <= lat);
`ifdef LEADING_ZERO_BLANK_EN
      exp_blank = (ed >= fs) && (ed <= fs + fh + 1) && m_hz;
`else
      exp_blank = 0;
`endif
    end
  end

  // Shift register: rdy low hold_len cycles after each load,
  // plus an optional extra hold applied between frames.
  initial begin
    i_srrdy = 1'b1;
    i_htens_zero = 1'b0;
    forever begin
      @(negedge i_clk);
      ld = o_srload;
      @(posedge i_clk);
      #1;
      i_htens_zero = 1'($urandom_range(0, 1));
      if (!i_rst_n) begin
        sr_cnt = 0;
        i_srrdy = 1'b1;
      end else begin
        if (ld) sr_cnt = hold_len;
        sr_busy = 0;
        if (sr_cnt > 0) begin
          sr_cnt--;
          sr_busy = 1;
        end
        if (ext_cnt > 0) begin
          ext_cnt--;
          sr_busy = 1;
        end
        i_srrdy = !sr_busy;
      end
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    @(negedge i_clk);
    if (!i_rst_n) begin
      chk("rst_outputs",
          {o_srload, o_latch, o_cnt_en, o_blank, o_busy, o_muxsel}, 0);
    end else begin
      chk("cnt_en", o_cnt_en, exp_cnt_en);
      chk("busy", o_busy, exp_busy);
      chk("blank", o_blank, exp_blank);
      if (o_srload) chk("srload_rdy", i_srrdy, 1);
      while (q.size() > 0 && q[0].ed < ed) begin
        checks++;
        errors++;
        $display("FAIL missed_event: got none expected latch=%0d mux=%0d at edge %0d",
                 q[0].is_latch, q[0].mux, q[0].ed);
        void'(q.pop_front());
      end
      if (o_srload || o_latch) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got load=%0d latch=%0d mux=%0d expected none (edge %0d)",
                   o_srload, o_latch, o_muxsel, ed);
        end else begin
          cur = q.pop_front();
          chk("ev_kind", o_latch, cur.is_latch);
          chk("ev_load", o_srload, !cur.is_latch);
          chk("ev_mux", o_muxsel, cur.mux);
          chk("ev_edge", ed, cur.ed);
        end
      end
    end
  end

  task automatic wait_latch();
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_latch && n < 2000);
    if (!o_latch) begin
      checks++;
      errors++;
      $display("FAIL latch_timeout: got no latch expected one within 2000 cycles");
    end
  endtask

  task automatic wait_third_load();
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!(o_srload && o_muxsel == 3'd3) && n < 2000);
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL load3_timeout: got no third load expected one within 2000 cycles");
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    #2 i_rst_n = 1'b1;

    repeat (3) wait_latch();

    // Long SR stall while idle: only one frame may queue.
    hold_len = 8;
    ext_cnt = 100;
    wait_latch();
    wait_latch();

    repeat (8) begin
      hold_len = $urandom_range(2, 10);
      ext_cnt = ($urandom_range(0, 3) == 0) ? 100 : $urandom_range(0, 12);
      wait_latch();
    end

    // Reset in the middle of a frame.
    hold_len = 8;
    wait_latch();
    wait_third_load();
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst",
        {o_srload, o_latch, o_cnt_en, o_blank, o_busy, o_muxsel}, 0);
    q.delete();
    ed = 0;
    pend = 0;
    fs = 1;
    lat = 0;
    idle_from = 0;
    exp_cnt_en = 0;
    exp_busy = 0;
    exp_blank = 0;
    ext_cnt = 0;
    repeat (3) @(negedge i_clk);
    #2 i_rst_n = 1'b1;

    repeat (3) begin
      hold_len = $urandom_range(2, 10);
      wait_latch();
    end
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
